// File: rtl/sc_scbc_utc_sched.sv
// Frame/transaction scheduler: SOF on each frame tick, then round-robin channel requests to the packet TX.
// START registered 1 cycle after Sof/Xfer entry; each packet is held until PKT_TX_COMP or the wait timeout.
module sc_scbc_utc_sched #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                ULPICLK,
    input  logic                ULPIRSTB,
    input  logic                UPS_OPERATIONAL,
    input  logic                FT_1MS,
    input  logic [NCH-1:0]      REQ_VALID,
    input  logic [NCH*4-1:0]    REQ_PID,
    input  logic [NCH*7-1:0]    REQ_ADR,
    input  logic [NCH*4-1:0]    REQ_EPN,
    input  logic [NCH*8-1:0]    REQ_DAT,
    input  logic [NCH*11-1:0]   REQ_NUM,
    output logic [NCH-1:0]      REQ_ACK,
    output logic [NCH-1:0]      REQ_ERR,
    output logic                PKT_TX_START,
    input  logic                PKT_TX_COMP,
    output logic [3:0]          PKT_TX_PID,
    output logic [6:0]          PKT_TX_ADR,
    output logic [3:0]          PKT_TX_EPN,
    output logic [7:0]          PKT_TX_DAT,
    output logic [10:0]         PKT_TX_NUM,
    output logic [10:0]         FRAME_NUM
);

    localparam int          PW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0]  PID_SOF   = 4'b0101;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef struct packed {
        logic [3:0]  pid;
        logic [6:0]  adr;
        logic [3:0]  epn;
        logic [7:0]  dat;
        logic [10:0] num;
    } pkt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_SOF_WAIT,
        ST_ARB,
        ST_XFER,
        ST_XFER_WAIT
    } state_t;

    // Assert is asynchronous through the synchroniser; release reaches the core after two edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    state_t          state_q, state_d;
    pkt_t            pkt_q, pkt_d;
    logic            start_q, start_d;
    logic [NCH-1:0]  ack_q, ack_d;
    logic [NCH-1:0]  err_q, err_d;
    logic [10:0]     frame_num_q, frame_num_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic            sof_pend_q, sof_pend_d;
    logic            frame_open_q, frame_open_d;
    logic [15:0]     wait_cnt_q, wait_cnt_d;

    logic            arb_found;
    logic [PW-1:0]   arb_sel;
    logic [PW-1:0]   arb_idx;
    int              idx;
    pkt_t            req_pkt;
    logic [PW-1:0]   grant_next;
    logic            wait_expired;

    // Round-robin search starting at rr_ptr, wrapping at NCH.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            arb_idx = idx[PW-1:0];
            if (!arb_found && REQ_VALID[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
    end

    always_comb begin
        req_pkt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_q == i[PW-1:0]) begin
                req_pkt.pid = REQ_PID[4*i +: 4];
                req_pkt.adr = REQ_ADR[7*i +: 7];
                req_pkt.epn = REQ_EPN[4*i +: 4];
                req_pkt.dat = REQ_DAT[8*i +: 8];
                req_pkt.num = REQ_NUM[11*i +: 11];
            end
        end
    end

    assign grant_next   = (grant_q == PW'(NCH - 1)) ? '0 : grant_q + 1'b1;
    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d      = state_q;
        pkt_d        = pkt_q;
        start_d      = start_q;
        ack_d        = '0;
        err_d        = '0;
        frame_num_d  = frame_num_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        sof_pend_d   = sof_pend_q;
        frame_open_d = frame_open_q;
        wait_cnt_d   = wait_cnt_q;

        // A tick arriving while busy is remembered so the SOF goes out as soon as we are idle.
        if (FT_1MS && UPS_OPERATIONAL && (state_q != ST_IDLE)) sof_pend_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (UPS_OPERATIONAL && (FT_1MS || sof_pend_q)) begin
                    state_d    = ST_SOF;
                    sof_pend_d = 1'b0;
                end else if (UPS_OPERATIONAL && frame_open_q && (|REQ_VALID)) begin
                    state_d = ST_ARB;
                end
            end
            ST_SOF: begin
                start_d    = 1'b1;
                pkt_d      = '{pid: PID_SOF, adr: 7'd0, epn: 4'd0, dat: 8'd0, num: frame_num_q};
                wait_cnt_d = '0;
                state_d    = ST_SOF_WAIT;
            end
            ST_SOF_WAIT: begin
                if (PKT_TX_COMP || wait_expired) begin
                    start_d      = 1'b0;
                    pkt_d        = '0;
                    frame_num_d  = frame_num_q + 11'd1;
                    frame_open_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_ARB: begin
                if (UPS_OPERATIONAL && arb_found) begin
                    grant_d = arb_sel;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                start_d    = 1'b1;
                pkt_d      = req_pkt;
                wait_cnt_d = '0;
                state_d    = ST_XFER_WAIT;
            end
            ST_XFER_WAIT: begin
                if (PKT_TX_COMP || wait_expired) begin
                    start_d  = 1'b0;
                    pkt_d    = '0;
                    rr_ptr_d = grant_next;
                    state_d  = ST_IDLE;
                    if (PKT_TX_COMP) ack_d[grant_q] = 1'b1;
                    else             err_d[grant_q] = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!UPS_OPERATIONAL) begin
            sof_pend_d   = 1'b0;
            frame_open_d = 1'b0;
            frame_num_d  = '0;
        end
    end

    always_ff @(posedge ULPICLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pkt_q        <= '0;
            start_q      <= 1'b0;
            ack_q        <= '0;
            err_q        <= '0;
            frame_num_q  <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            sof_pend_q   <= 1'b0;
            frame_open_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pkt_q        <= pkt_d;
            start_q      <= start_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            frame_num_q  <= frame_num_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            sof_pend_q   <= sof_pend_d;
            frame_open_q <= frame_open_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign PKT_TX_START = start_q;
    assign PKT_TX_PID   = pkt_q.pid;
    assign PKT_TX_ADR   = pkt_q.adr;
    assign PKT_TX_EPN   = pkt_q.epn;
    assign PKT_TX_DAT   = pkt_q.dat;
    assign PKT_TX_NUM   = pkt_q.num;
    assign REQ_ACK      = ack_q;
    assign REQ_ERR      = err_q;
    assign FRAME_NUM    = frame_num_q;

endmodule

// File: tb/tb_sc_scbc_utc_sched.sv
// Directed bench for sc_scbc_utc_sched (NCH=4, TIMEOUT=8): SOF timing, round-robin grants,
// pending SOF, timeout abort, frame wrap, operational drop and mid-transaction reset.
module tb_sc_scbc_utc_sched;

    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rstb;
    logic              ups;
    logic              ft;
    logic [NCH-1:0]    req_valid;
    logic [NCH*4-1:0]  req_pid;
    logic [NCH*7-1:0]  req_adr;
    logic [NCH*4-1:0]  req_epn;
    logic [NCH*8-1:0]  req_dat;
    logic [NCH*11-1:0] req_num;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    err;
    logic              start;
    logic              comp;
    logic [3:0]        pid;
    logic [6:0]        adr;
    logic [3:0]        epn;
    logic [7:0]        dat;
    logic [10:0]       num;
    logic [10:0]       frame_num;

    int n_assert = 0;
    int n_fail   = 0;

    sc_scbc_utc_sched #(.NCH(NCH), .TIMEOUT(8)) dut (
        .ULPICLK         (clk),
        .ULPIRSTB        (rstb),
        .UPS_OPERATIONAL (ups),
        .FT_1MS          (ft),
        .REQ_VALID       (req_valid),
        .REQ_PID         (req_pid),
        .REQ_ADR         (req_adr),
        .REQ_EPN         (req_epn),
        .REQ_DAT         (req_dat),
        .REQ_NUM         (req_num),
        .REQ_ACK         (ack),
        .REQ_ERR         (err),
        .PKT_TX_START    (start),
        .PKT_TX_COMP     (comp),
        .PKT_TX_PID      (pid),
        .PKT_TX_ADR      (adr),
        .PKT_TX_EPN      (epn),
        .PKT_TX_DAT      (dat),
        .PKT_TX_NUM      (num),
        .FRAME_NUM       (frame_num)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (!start && k < 20) begin
            tick(1);
            k++;
        end
        chk(tag, {63'd0, start}, 64'd1);
    endtask

    // Complete one SOF: tick in Idle, START on the following edge, COMP on the next.
    task automatic sof_cycle(input logic [10:0] exp_num);
        ft = 1'b1;
        tick(1);
        ft = 1'b0;
        chk("sof_not_early", {63'd0, start}, 64'd0);
        tick(1);
        chk("sof_start", {63'd0, start}, 64'd1);
        chk("sof_pid", {60'd0, pid}, 64'd5);
        chk("sof_num", {53'd0, num}, {53'd0, exp_num});
        comp = 1'b1;
        tick(1);
        comp = 1'b0;
        chk("sof_done", {63'd0, start}, 64'd0);
        chk("sof_frame", {53'd0, frame_num}, {53'd0, exp_num + 11'd1});
    endtask

    task automatic xfer(input int ch);
        wait_start($sformatf("xfer_start_ch%0d", ch));
        chk($sformatf("xfer_pid_ch%0d", ch), {60'd0, pid}, 64'(ch + 1));
        chk($sformatf("xfer_adr_ch%0d", ch), {57'd0, adr}, 64'(8'h10 + ch));
        chk($sformatf("xfer_epn_ch%0d", ch), {60'd0, epn}, 64'(15 - ch));
        chk($sformatf("xfer_dat_ch%0d", ch), {56'd0, dat}, 64'(8'hA0 + ch));
        chk($sformatf("xfer_num_ch%0d", ch), {53'd0, num}, 64'(11'h100 + ch));
        comp = 1'b1;
        tick(1);
        comp = 1'b0;
        chk("xfer_start_clr", {63'd0, start}, 64'd0);
        chk("xfer_pid_clr", {60'd0, pid}, 64'd0);
        chk($sformatf("xfer_ack_ch%0d", ch), {60'd0, ack}, 64'(1 << ch));
        chk("xfer_no_err", {60'd0, err}, 64'd0);
        tick(1);
        chk("xfer_ack_one_cycle", {60'd0, ack}, 64'd0);
    endtask

    initial begin
        int c;
        rstb      = 1'b1;
        ups       = 1'b0;
        ft        = 1'b0;
        comp      = 1'b0;
        req_valid = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            req_pid[4*ch +: 4]   = 4'(ch + 1);
            req_adr[7*ch +: 7]   = 7'(8'h10 + ch);
            req_epn[4*ch +: 4]   = 4'(15 - ch);
            req_dat[8*ch +: 8]   = 8'(8'hA0 + ch);
            req_num[11*ch +: 11] = 11'(11'h100 + ch);
        end

        #2 rstb = 1'b0;
        #1;
        chk("rst_start", {63'd0, start}, 64'd0);
        chk("rst_frame", {53'd0, frame_num}, 64'd0);
        chk("rst_ack", {60'd0, ack}, 64'd0);
        chk("rst_err", {60'd0, err}, 64'd0);
        chk("rst_pid", {60'd0, pid}, 64'd0);
        tick(2);
        rstb = 1'b1;
        tick(3);

        // Operational with requests but no SOF yet: nothing may be serviced.
        ups       = 1'b1;
        req_valid = 4'b1011;
        tick(4);
        chk("no_req_before_sof", {63'd0, start}, 64'd0);

        ft = 1'b1;
        tick(1);
        ft = 1'b0;
        chk("sof1_edge1", {63'd0, start}, 64'd0);
        tick(1);
        chk("sof1_edge2_start", {63'd0, start}, 64'd1);
        chk("sof1_pid", {60'd0, pid}, 64'd5);
        chk("sof1_num", {53'd0, num}, 64'd0);
        chk("sof1_adr", {57'd0, adr}, 64'd0);
        tick(1);
        chk("sof1_hold", {63'd0, start}, 64'd1);
        chk("sof1_hold_pid", {60'd0, pid}, 64'd5);
        comp = 1'b1;
        tick(1);
        comp = 1'b0;
        chk("sof1_comp_start", {63'd0, start}, 64'd0);
        chk("sof1_frame", {53'd0, frame_num}, 64'd1);
        chk("sof1_pid_clr", {60'd0, pid}, 64'd0);

        xfer(0);
        xfer(1);
        xfer(3);
        xfer(0);

        // Frame tick during XferWait: transfer finishes, then the SOF jumps ahead of requests.
        wait_start("p33_start");
        chk("p33_pid_ch1", {60'd0, pid}, 64'd2);
        ft = 1'b1;
        tick(1);
        ft = 1'b0;
        chk("p33_still_busy", {63'd0, start}, 64'd1);
        comp = 1'b1;
        tick(1);
        comp = 1'b0;
        chk("p33_ack_ch1", {60'd0, ack}, 64'b0010);
        req_valid = 4'b0100;
        wait_start("p33_sof_start");
        chk("p33_sof_pid", {60'd0, pid}, 64'd5);
        chk("p33_sof_num", {53'd0, num}, 64'd1);
        comp = 1'b1;
        tick(1);
        comp = 1'b0;
        chk("p33_frame", {53'd0, frame_num}, 64'd2);

        // Channel 2 never completes: abort after 8 wait cycles.
        wait_start("to_start");
        chk("to_pid_ch2", {60'd0, pid}, 64'd3);
        c = 0;
        while (start && c < 30) begin
            c++;
            tick(1);
        end
        chk("to_start_cycles", 64'(c), 64'd8);
        chk("to_err_ch2", {60'd0, err}, 64'b0100);
        chk("to_no_ack", {60'd0, ack}, 64'd0);
        chk("to_pid_clr", {60'd0, pid}, 64'd0);
        req_valid = 4'b1111;
        tick(1);
        chk("to_err_one_cycle", {60'd0, err}, 64'd0);
        xfer(3);
        req_valid = 4'b0000;
        tick(3);
        chk("arb_none_idle", {63'd0, start}, 64'd0);

        for (int f = 2; f < 2047; f++) sof_cycle(11'(f));
        chk("frame_2047", {53'd0, frame_num}, 64'd2047);
        sof_cycle(11'd2047);
        chk("frame_wrap", {53'd0, frame_num}, 64'd0);
        sof_cycle(11'd0);

        ups = 1'b0;
        tick(1);
        chk("nonop_frame0", {53'd0, frame_num}, 64'd0);
        req_valid = 4'b0001;
        tick(1);
        ups = 1'b1;
        tick(5);
        chk("reop_no_service", {63'd0, start}, 64'd0);
        sof_cycle(11'd0);

        wait_start("rst_xfer_start");
        chk("rst_xfer_pid", {60'd0, pid}, 64'd1);
        rstb = 1'b0;
        #1;
        chk("midrst_start", {63'd0, start}, 64'd0);
        chk("midrst_pid", {60'd0, pid}, 64'd0);
        chk("midrst_num", {53'd0, num}, 64'd0);
        chk("midrst_frame", {53'd0, frame_num}, 64'd0);
        comp = 1'b1;
        tick(1);
        chk("midrst_no_ack", {60'd0, ack}, 64'd0);
        chk("midrst_no_err", {60'd0, err}, 64'd0);
        comp = 1'b0;
        rstb = 1'b1;
        tick(5);
        chk("postrst_idle", {63'd0, start}, 64'd0);
        chk("postrst_frame", {53'd0, frame_num}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
